calc_op_sched: RTL

- Command scheduler for the calculator ALU/accumulator datapath.
- Buffers queued (alu_op, operand) commands in a FIFO and issues them one at a time to the ALU.
- Pulses the accumulator write or clear strobe at the right cycle, replacing direct button-driven accumulator updates.
- Sits between the input/encoder logic (producer) and the ALU plus accumulator register (consumer).

---
 rtl/calc_op_sched.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/calc_op_sched.sv
// rtl/calc_op_sched.sv - command FIFO and issue scheduler for the calculator ALU/accumulator
//
// Buffers (op, operand) commands from the input logic and issues them one at
// a time to the ALU. Each command goes ISSUE -> WAIT (ALU_LAT cycles) ->
// COMMIT. A CLR_OP command skips WAIT and strobes acc_clr instead of acc_we.
//
// Optional feature macro: CALC_OP_SCHED_HALT_ZERO_EN (halt-on-zero).
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   cmd_valid     producer offers a command
//   cmd_ready     FIFO can accept (not full, and not halted)
//   cmd_op        ALU op code or CLR_OP
//   cmd_operand   signed operand, forwarded to alu_op2
//   run           level enable for draining the queue
//   alu_op        registered op code to the ALU
//   alu_op2       registered operand to the ALU
//   acc_we        one-cycle accumulator load strobe
//   acc_clr       one-cycle accumulator clear strobe
//   alu_zero      ALU zero flag, sampled at commit (halt feature only)
//   busy          FSM is not in IDLE
//   count         FIFO occupancy
//   halted        halt-on-zero status (0 without the feature)

module calc_op_sched #(
    parameter int         DEPTH   = 8,
    parameter int         ALU_LAT = 1,
    parameter logic [3:0] CLR_OP  = 4'hF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_op,
    input  logic [15:0]              cmd_operand,
    input  logic                     run,
    output logic [3:0]               alu_op,
    output logic [15:0]              alu_op2,
    output logic                     acc_we,
    output logic                     acc_clr,
    input  logic                     alu_zero,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Wait-counter preload; the WAIT state lasts exactly ALU_LAT cycles.
    localparam logic [3:0] LAT_M1 = (ALU_LAT == 0) ? 4'd0 : 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t          state, state_d;
    logic [19:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [3:0]      wait_cnt, wait_d;
    logic            clr_flag, clr_d;
    logic [3:0]      alu_op_d;
    logic [15:0]     alu_op2_d;
    logic            acc_we_d, acc_clr_d, busy_d;
    logic            full, push, pop;
    logic [3:0]      head_op, next_op;
    logic [15:0]     head_operand, next_operand;
    logic            can_start;

    assign full         = (count == CW'(DEPTH));
    assign push         = cmd_valid && cmd_ready;
    assign pop          = (state == COMMIT);
    assign head_op      = mem[rd_ptr][19:16];
    assign head_operand = mem[rd_ptr][15:0];
    // Entry behind the head: becomes the head once COMMIT pops.
    assign next_op      = mem[rd_ptr + AW'(1)][19:16];
    assign next_operand = mem[rd_ptr + AW'(1)][15:0];

`ifdef CALC_OP_SCHED_HALT_ZERO_EN
    logic halted_q, halted_d, flush;
    assign halted    = halted_q;
    assign cmd_ready = !full && !halted_q;
    assign can_start = run && (count != '0) && !halted_q;
`else
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;
    assign halted    = 1'b0;
    assign cmd_ready = !full;
    assign can_start = run && (count != '0);
`endif

    // Storage array carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_operand};
        end
    end

    always_comb begin
        state_d   = state;
        wait_d    = wait_cnt;
        clr_d     = clr_flag;
        alu_op_d  = alu_op;
        alu_op2_d = alu_op2;
`ifdef CALC_OP_SCHED_HALT_ZERO_EN
        halted_d  = halted_q;
        flush     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (can_start) begin
                    // A clear command leaves the ALU inputs untouched.
                    if (head_op != CLR_OP) begin
                        alu_op_d  = head_op;
                        alu_op2_d = head_operand;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (head_op == CLR_OP) begin
                    clr_d   = 1'b1;
                    state_d = COMMIT;
                end else begin
                    clr_d = 1'b0;
                    if (ALU_LAT == 0) begin
                        state_d = COMMIT;
                    end else begin
                        wait_d  = LAT_M1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_d = COMMIT;
                end else begin
                    wait_d = wait_cnt - 4'd1;
                end
            end
            COMMIT: begin
`ifdef CALC_OP_SCHED_HALT_ZERO_EN
                if (acc_we && alu_zero) begin
                    flush    = 1'b1;
                    halted_d = 1'b1;
                    state_d  = IDLE;
                end else
`endif
                if (run && (count != CW'(1))) begin
                    if (next_op != CLR_OP) begin
                        alu_op_d  = next_op;
                        alu_op2_d = next_operand;
                    end
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes and busy are registered from the next state (Moore outputs).
        acc_we_d  = (state_d == COMMIT) && !clr_d;
        acc_clr_d = (state_d == COMMIT) && clr_d;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            clr_flag <= 1'b0;
            alu_op   <= 4'd0;
            alu_op2  <= 16'd0;
            acc_we   <= 1'b0;
            acc_clr  <= 1'b0;
            busy     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
`ifdef CALC_OP_SCHED_HALT_ZERO_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            wait_cnt <= wait_d;
            clr_flag <= clr_d;
            alu_op   <= alu_op_d;
            alu_op2  <= alu_op2_d;
            acc_we   <= acc_we_d;
            acc_clr  <= acc_clr_d;
            busy     <= busy_d;
`ifdef CALC_OP_SCHED_HALT_ZERO_EN
            halted_q <= halted_d;
            if (flush) begin
                // Discard everything, including a push on this same edge.
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else
`endif
            begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
